// File: rtl/ksa_pkg.sv
// ksa_pkg: shared state encoding and character-class constants for the key-search datapath
package ksa_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} dmc_state_t;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LO    = 8'h61;
  localparam logic [7:0] CH_HI    = 8'h7A;
endpackage

// File: rtl/dm_char_class.sv
// dm_char_class: flags a byte as legal plaintext (space or lowercase letter)
module dm_char_class
  import ksa_pkg::*;
(
  input  logic [7:0] ch,
  output logic       legal
);
  assign legal = (ch == CH_SPACE) || (ch >= CH_LO && ch <= CH_HI);
endmodule

// File: rtl/dm_checker.sv
// dm_checker: walks the decrypted-message RAM and reports the first illegal byte, if any
module dm_checker
  import ksa_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        rddata,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [ADDR_W-1:0] bad_index,
  output logic [7:0]        bad_char
);
  localparam int CW = $clog2(RD_LAT + 1);
  dmc_state_t state, nxt;
  logic [ADDR_W:0] idx;
  logic [CW-1:0] cnt;
  logic legal, last;
  dm_char_class u_class (.ch(rddata), .legal(legal));
  // one spare bit on idx so MSG_LEN = 2**ADDR_W compares without wrapping
  assign last = idx == (ADDR_W+1)'(MSG_LEN - 1);
  assign addr = idx[ADDR_W-1:0];
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? ISSUE : IDLE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = (cnt == '0) ? CHECK : WAIT;
      CHECK:   nxt = (!legal || last) ? DONE : ISSUE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state inside {ISSUE, WAIT, CHECK};
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      idx       <= '0;
      cnt       <= '0;
      valid     <= 1'b0;
      bad_index <= '0;
      bad_char  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          idx       <= '0;
          valid     <= 1'b0;
          bad_index <= '0;
          bad_char  <= '0;
        end
        ISSUE: cnt <= CW'(RD_LAT - 1);
        WAIT:  if (cnt != '0) cnt <= cnt - 1'b1;
        CHECK: if (!legal) begin
          bad_index <= addr;
          bad_char  <= rddata;
          valid     <= 1'b0;
        end else if (last) valid <= 1'b1;
        else idx <= idx + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_dm_checker.sv
// tb_dm_checker: randomized and directed scoreboard bench for dm_checker at RD_LAT 1 and 2
module tb_dm_checker;
  typedef struct {
    logic       v;
    logic [7:0] idx;
    logic [7:0] ch;
    int         cyc;
  } exp_t;

  localparam int LAT [2] = '{1, 2};

  logic clk = 0, rst_n = 0;
  logic [1:0] start = '0, busy, done, valid;
  logic [7:0] addr [2], bad_index [2], bad_char [2], q [2], p2;
  logic [7:0] mem [256];
  exp_t sb [2][$];
  exp_t e;
  int cyc = 0, launch [2] = '{0, 0}, n;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    q[0] <= mem[addr[0]];
    p2   <= mem[addr[1]];
    q[1] <= p2;
  end

  dm_checker #(.MSG_LEN(32), .ADDR_W(8), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]), .rddata(q[0]),
    .busy(busy[0]), .done(done[0]), .valid(valid[0]), .bad_index(bad_index[0]), .bad_char(bad_char[0]));
  dm_checker #(.MSG_LEN(32), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]), .rddata(q[1]),
    .busy(busy[1]), .done(done[1]), .valid(valid[1]), .bad_index(bad_index[1]), .bad_char(bad_char[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // verdict straight from the character rules: first non-legal byte wins, else pass
  function automatic exp_t model(input int lat);
    for (int k = 0; k < 32; k++)
      if (!(mem[k] == 8'h20 || (mem[k] >= 8'h61 && mem[k] <= 8'h7a)))
        return '{1'b0, 8'(k), mem[k], (k + 1) * (lat + 2) + 1};
    return '{1'b1, 8'd0, 8'd0, 32 * (lat + 2) + 1};
  endfunction

  always @(negedge clk)
    if (rst_n)
      for (int d = 0; d < 2; d++) begin
        n = cyc - launch[d] + 1;
        if (busy[d]) chk($sformatf("addr_dut%0d_cyc%0d", d, n), addr[d], (n - 1) / (LAT[d] + 2));
        if (done[d]) begin
          chk($sformatf("done_expected_dut%0d", d), sb[d].size() > 0, 1);
          if (sb[d].size() > 0) begin
            e = sb[d].pop_front();
            chk($sformatf("valid_dut%0d", d), valid[d], e.v);
            chk($sformatf("bad_index_dut%0d", d), bad_index[d], e.idx);
            chk($sformatf("bad_char_dut%0d", d), bad_char[d], e.ch);
            chk($sformatf("done_cycle_dut%0d", d), n, e.cyc);
            chk($sformatf("busy_at_done_dut%0d", d), busy[d], 0);
          end
        end
      end

  task automatic launch_run(input int d);
    @(negedge clk);
    start[d] = 1'b1;
    sb[d].push_back(model(LAT[d]));
    @(posedge clk);
    #1 launch[d] = cyc;
    @(negedge clk);
    start[d] = 1'b0;
    chk("valid_cleared", valid[d], 0);
    chk("bad_index_cleared", bad_index[d], 0);
    chk("bad_char_cleared", bad_char[d], 0);
    chk("busy_first_cycle", busy[d], 1);
  endtask

  task automatic wait_done(input int d);
    int i;
    for (i = 0; i < 2000 && sb[d].size() > 0; i++) @(negedge clk);
    if (sb[d].size() > 0) begin
      chk("done_timeout", sb[d].size(), 0);
      sb[d].delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int d, input int c);
    while (cyc - launch[d] + 1 < c) @(negedge clk);
  endtask

  task automatic fill(input logic [7:0] b);
    for (int k = 0; k < 256; k++) mem[k] = b;
  endtask

  initial begin
    fill(8'h61);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_valid", valid[d], 0);
      chk("rst_addr", addr[d], 0);
      chk("rst_bad_index", bad_index[d], 0);
      chk("rst_bad_char", bad_char[d], 0);
    end
    rst_n = 1'b1;
    launch_run(0); wait_done(0);
    fill(8'h7a); mem[5] = 8'h41;
    launch_run(0); wait_done(0);
    for (int k = 0; k < 32; k++) mem[k] = (k % 3 == 0) ? 8'h20 : (k % 3 == 1) ? 8'h61 : 8'h7a;
    launch_run(0); wait_done(0);
    mem[31] = 8'h60;
    launch_run(0); wait_done(0);
    mem[31] = 8'h7b;
    launch_run(0); wait_done(0);
    mem[31] = 8'h1f; mem[0] = 8'h21;
    launch_run(0); wait_done(0);
    fill(8'h61);
    launch_run(0);
    wait_cyc(0, 40);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy[0], 0);
    chk("abort_addr", addr[0], 0);
    chk("abort_valid", valid[0], 0);
    sb[0].delete();
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    launch_run(0); wait_done(0);
    launch_run(0);
    wait_cyc(0, 10); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_cyc(0, 50); start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    wait_done(0);
    for (int r = 0; r < 8; r++) begin
      int den = (r == 0) ? 0 : $urandom_range(10, 120);
      for (int k = 0; k < 32; k++) begin
        int c = $urandom_range(0, 26);
        mem[k] = (c == 26) ? 8'h20 : 8'(8'h61 + c);
        if (den != 0 && $urandom_range(1, den) == 1) mem[k] = 8'($urandom_range(0, 255));
      end
      launch_run(0); wait_done(0);
    end
    fill(8'h20);
    launch_run(1); wait_done(1);
    mem[17] = 8'hff;
    launch_run(1); wait_done(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
